// File: rtl/darkram_arb_pkg.sv
// darkram_arb_pkg: shared state encoding and constants for the darkram X-bus arbiter.
package darkram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Read data returned to the granted master when the watchdog aborts a transfer.
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/darkram_arb_if.sv
// darkram_arb_if: one darkram-style data bus (request, strobes, address, data, ack).
// The master modport drives the request side; the slave modport answers with ack and read data.
interface darkram_arb_if;

  logic        DREQ;
  logic        RD;
  logic        WR;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic [31:0] ATAI;
  logic [31:0] ATAO;
  logic        DACK;

  modport master (
    output DREQ, RD, WR, BE, ADDR, ATAI,
    input  ATAO, DACK
  );

  modport slave (
    input  DREQ, RD, WR, BE, ADDR, ATAI,
    output ATAO, DACK
  );

endinterface

// File: rtl/darkram_arb_rr.sv
// darkram_arb_rr: two-way round-robin pick. A lone requester wins; on a tie
// the priority bit names the winner. Only meaningful while the arbiter is idle.
module darkram_arb_rr (
  input  logic [1:0] req_i,
  input  logic       pri_i,
  output logic       gnt_o
);

  // Grant choice from the request pair and the priority bit
  always_comb begin
    gnt_o = pri_i;
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = pri_i;
    endcase
  end

endmodule

// File: rtl/darkram_arb.sv
// darkram_arb: two-master round-robin arbiter for the darkram X data port.
// Master 0 is the CPU core, master 1 the loader/debug DMA.
// Optional watchdog abort enabled by defining DARKRAM_ARB_TIMEOUT_EN.
module darkram_arb
  import darkram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESN,
  darkram_arb_if.slave         M0,
  darkram_arb_if.slave         M1,
  darkram_arb_if.master        X,
  output logic                 ERR,
  output logic [3:0]           DEBUG
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("darkram_arb: TIMEOUT must lie in 2..255");
  end

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   pri_q, pri_d;
  logic   rr_gnt;
  logic   sel_dreq;
  logic   abort;

`ifdef DARKRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
  logic [7:0] wdog_q, wdog_d;
`endif

  darkram_arb_rr u_rr (
    .req_i ({M1.DREQ, M0.DREQ}),
    .pri_i (pri_q),
    .gnt_o (rr_gnt)
  );

  assign sel_dreq = gnt_q ? M1.DREQ : M0.DREQ;

  // Watchdog abort: fires in the BUSY cycle whose increment would reach TIMEOUT,
  // so with TIMEOUT=N the abort lands in the Nth BUSY cycle. A real ack wins.
`ifdef DARKRAM_ARB_TIMEOUT_EN
  always_comb begin
    abort = (state_q == BUSY) && !X.DACK && sel_dreq && ((wdog_q + 8'd1) == TIMEOUT_W);
  end
`else
  always_comb begin
    abort = 1'b0;
  end
`endif

  // State, grant, priority and watchdog registers
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      pri_q   <= 1'b0;
`ifdef DARKRAM_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
`ifdef DARKRAM_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // Next-state: grant in IDLE, release on ack/abort (priority flips) or on a dropped request (priority kept)
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
`ifdef DARKRAM_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (M0.DREQ || M1.DREQ) begin
          state_d = BUSY;
          gnt_d   = rr_gnt;
`ifdef DARKRAM_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (X.DACK || abort) begin
          state_d = IDLE;
          pri_d   = ~gnt_q;
        end else if (!sel_dreq) begin
          state_d = IDLE;
        end else begin
`ifdef DARKRAM_ARB_TIMEOUT_EN
          wdog_d  = wdog_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: forward the granted master to X while BUSY, route ack/data back to it only
  always_comb begin
    X.DREQ  = 1'b0;
    X.RD    = 1'b0;
    X.WR    = 1'b0;
    X.BE    = '0;
    X.ADDR  = '0;
    X.ATAI  = '0;
    M0.DACK = 1'b0;
    M0.ATAO = '0;
    M1.DACK = 1'b0;
    M1.ATAO = '0;
    ERR     = abort;
    if (state_q == BUSY) begin
      if (gnt_q) begin
        X.DREQ  = M1.DREQ;
        X.RD    = M1.RD;
        X.WR    = M1.WR;
        X.BE    = M1.BE;
        X.ADDR  = M1.ADDR;
        X.ATAI  = M1.ATAI;
        M1.DACK = X.DACK | abort;
        M1.ATAO = abort ? ABORT_DATA : X.ATAO;
      end else begin
        X.DREQ  = M0.DREQ;
        X.RD    = M0.RD;
        X.WR    = M0.WR;
        X.BE    = M0.BE;
        X.ADDR  = M0.ADDR;
        X.ATAI  = M0.ATAI;
        M0.DACK = X.DACK | abort;
        M0.ATAO = abort ? ABORT_DATA : X.ATAO;
      end
    end
    DEBUG = {state_q == BUSY, gnt_q, abort, X.DACK};
  end

endmodule

// File: tb/tb_darkram_arb.sv
module tb_darkram_arb;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       resn = 1'b0;
  logic       err;
  logic [3:0] dbg;

  darkram_arb_if m0_if ();
  darkram_arb_if m1_if ();
  darkram_arb_if x_if ();

  darkram_arb #(.TIMEOUT(4)) dut (
    .CLK   (clk),
    .RESN  (resn),
    .M0    (m0_if),
    .M1    (m1_if),
    .X     (x_if),
    .ERR   (err),
    .DEBUG (dbg)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];

  logic [31:0] rmem [0:255];
  logic [31:0] dmem [0:255];
  logic        mute = 1'b0;
  int          rd_cnt = 0;
  logic [3:0]  last_wbe = '0;
  logic        prev_dack = 1'b0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endfunction

  // darkram stand-in: writes ack combinationally, reads ack in their second requested cycle
  always_comb begin
    x_if.DACK = !mute && x_if.DREQ && (x_if.WR || (x_if.RD && rd_cnt == 1));
    x_if.ATAO = (x_if.DREQ && x_if.RD) ? dmem[x_if.ADDR[9:2]] : '0;
  end

  always @(posedge clk) begin
    rd_cnt <= (x_if.DREQ && x_if.RD && !x_if.DACK) ? rd_cnt + 1 : 0;
    if (x_if.DREQ && x_if.WR && x_if.DACK) begin
      for (int b = 0; b < 4; b++)
        if (x_if.BE[b]) dmem[x_if.ADDR[9:2]][b*8 +: 8] <= x_if.ATAI[b*8 +: 8];
      last_wbe <= x_if.BE;
    end
  end

  task automatic mon_port(input int m, input logic dack, input logic [31:0] atao);
    exp_t e;
    if (!dack) return;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_dack_m%0d: got DACK=1 required DACK=0", m);
      return;
    end
    if (m == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.rd) check($sformatf("atao_m%0d", m), atao, e.data);
    check($sformatf("err_m%0d", m), 32'(err), 32'(e.err));
    if (order_q.size() != 0) check("grant_order", m, order_q.pop_front());
  endtask

  // Monitor: consumes the scoreboard whenever a master sees DACK
  always @(negedge clk) begin
    if (m0_if.DACK && m1_if.DACK) check("both_dack", 32'd1, 32'd0);
    if (prev_dack) check("idle_gap_xdreq", 32'(x_if.DREQ), 32'd0);
    if (err && !m0_if.DACK && !m1_if.DACK) check("err_without_dack", 32'(err), 32'd0);
    mon_port(0, m0_if.DACK, m0_if.ATAO);
    mon_port(1, m1_if.DACK, m1_if.ATAO);
    prev_dack <= m0_if.DACK | m1_if.DACK;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic rd, input logic wr,
                       input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_if.DREQ = req; m0_if.RD = rd; m0_if.WR = wr;
      m0_if.BE = be; m0_if.ADDR = a; m0_if.ATAI = d;
    end else begin
      m1_if.DREQ = req; m1_if.RD = rd; m1_if.WR = wr;
      m1_if.BE = be; m1_if.ADDR = a; m1_if.ATAI = d;
    end
  endtask

  // One master transfer: push the expected response, request, wait for DACK, drop the cycle after
  task automatic do_xfer(input int m, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] d, input bit exp_err, output int lat);
    exp_t       e;
    logic [7:0] idx;
    logic       ack;
    idx = addr[9:2];
    if (exp_err) begin
      e = '{rd: 1'b1, err: 1'b1, data: 32'hDEADBEEF};
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) rmem[idx][b*8 +: 8] = d[b*8 +: 8];
      e = '{rd: 1'b0, err: 1'b0, data: 32'h0};
    end else begin
      e = '{rd: 1'b1, err: 1'b0, data: rmem[idx]};
    end
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(m, 1'b1, !wr, wr, be, addr, d);
    lat = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ack = (m == 0) ? m0_if.DACK : m1_if.DACK;
      if (ack) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check($sformatf("dack_wait_m%0d", m), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drive(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rand_master(input int m, input int n);
    int          lat;
    bit          wr;
    logic [31:0] base;
    logic [31:0] addr;
    base = (m == 0) ? 32'h100 : 32'h200;
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = base + 32'($urandom_range(0, 63)) * 32'd4;
      do_xfer(m, wr, addr, 4'($urandom), $urandom, 1'b0, lat);
      tick($urandom_range(1, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) begin
      rmem[i] = '0;
      dmem[i] <= '0;
    end
    rmem[4] = 32'h12345678;
    dmem[4] <= 32'h12345678;
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    tick(2);
    check("rst_xdreq", 32'(x_if.DREQ), 32'd0);
    check("rst_xstrb", 32'({x_if.RD, x_if.WR, x_if.BE}), 32'd0);
    check("rst_xaddr", x_if.ADDR, 32'd0);
    check("rst_xatai", x_if.ATAI, 32'd0);
    check("rst_dack", 32'({m0_if.DACK, m1_if.DACK}), 32'd0);
    check("rst_atao0", m0_if.ATAO, 32'd0);
    check("rst_atao1", m1_if.ATAO, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_debug", 32'(dbg), 32'd0);
    resn = 1'b1;
    tick(2);

    // Uncontended read and write latencies, byte-enable forwarding
    do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, lat);
    check("rd_latency", lat, 32'd2);
    do_xfer(1, 1'b1, 32'h20, 4'b0011, 32'hAABBCCDD, 1'b0, lat);
    check("wr_latency", lat, 32'd1);
    check("xbe_forward", 32'(last_wbe), 32'(4'b0011));
    do_xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, lat);
    check("rd_back_latency", lat, 32'd2);
    tick(1);

    // Continuous contention from reset alternates starting with M0
    resn = 1'b0;
    tick(2);
    resn = 1'b1;
    tick(1);
    order_q = '{0, 1, 0, 1};
    fork
      begin do_xfer(0, 1'b0, 32'h104, 4'hF, 32'h0, 1'b0, lat); tick(1);
            do_xfer(0, 1'b0, 32'h108, 4'hF, 32'h0, 1'b0, lat); end
      begin do_xfer(1, 1'b0, 32'h204, 4'hF, 32'h0, 1'b0, lat); tick(1);
            do_xfer(1, 1'b0, 32'h208, 4'hF, 32'h0, 1'b0, lat); end
    join
    check("order_alt_consumed", order_q.size(), 32'd0);
    tick(1);

    // M1 breaks protocol after M0 completed (priority is M1 and must stay M1)
    do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, lat);
    tick(1);
    mute = 1'b1;
    drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h210, 32'h0);
    tick(3);
    check("brk_busy", 32'(dbg[3:2]), 32'd3);
    check("brk_xdreq", 32'(x_if.DREQ), 32'd1);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("brk_xdreq_drop", 32'(x_if.DREQ), 32'd0);
    tick(1);
    check("brk_idle", 32'(dbg[3]), 32'd0);
    mute = 1'b0;
    order_q = '{1, 0};
    fork
      do_xfer(0, 1'b0, 32'h110, 4'hF, 32'h0, 1'b0, lat);
      do_xfer(1, 1'b0, 32'h214, 4'hF, 32'h0, 1'b0, lat);
    join
    check("order_brk_consumed", order_q.size(), 32'd0);
    tick(1);

    // Unacknowledged transfer: watchdog abort, or indefinite wait without it
    mute = 1'b1;
`ifdef DARKRAM_ARB_TIMEOUT_EN
    do_xfer(0, 1'b0, 32'h120, 4'hF, 32'h0, 1'b1, lat);
    check("abort_latency", lat, 32'd4);
    tick(1);
`else
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h120, 32'h0);
    tick(10);
    check("hold_err", 32'(err), 32'd0);
    check("hold_busy", 32'(dbg[3]), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(2);
    check("hold_release_idle", 32'(dbg[3]), 32'd0);
`endif
    mute = 1'b0;

    // Asynchronous reset mid-transfer: XDREQ drops at once, priority back to M0
    do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, lat);
    tick(1);
    mute = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h130, 32'h0);
    tick(2);
    check("arst_pre_busy", 32'(dbg[3]), 32'd1);
    #2;
    resn = 1'b0;
    #1;
    check("arst_xdreq", 32'(x_if.DREQ), 32'd0);
    check("arst_debug", 32'(dbg), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(2);
    resn = 1'b1;
    mute = 1'b0;
    tick(1);
    check("arst_idle", 32'(dbg[3]), 32'd0);
    order_q = '{0, 1};
    fork
      do_xfer(0, 1'b0, 32'h134, 4'hF, 32'h0, 1'b0, lat);
      do_xfer(1, 1'b0, 32'h218, 4'hF, 32'h0, 1'b0, lat);
    join
    check("order_rst_consumed", order_q.size(), 32'd0);
    tick(1);

    // Randomized traffic from both masters on disjoint address windows
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    tick(3);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
